// File: rtl/push_frame_packer_if.sv
// push_frame_packer_if: sample input, FIFO push output and almost-full.
// The packer takes the master side; the source/FIFO model takes slave.
interface push_frame_packer_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] sdata;
  logic             senable;
  logic             oafull;
  logic [WIDTH-1:0] odata;
  logic             oenable;

  modport master (
    input  sdata,
    input  senable,
    input  oafull,
    output odata,
    output oenable
  );

  modport slave (
    output sdata,
    output senable,
    output oafull,
    input  odata,
    input  oenable
  );
endinterface

// File: rtl/push_frame_packer.sv
// push_frame_packer: frames a strobed sample stream with a seq trailer.
// Define FRAME_SUM_EN to append a modulo-2^WIDTH payload sum word.
module push_frame_packer #(
  parameter int WIDTH      = 8,
  parameter int FRAME_LEN  = 16,
  parameter int DROP_WIDTH = 8
) (
  input  logic                  wclock,
  input  logic                  resetn,
  push_frame_packer_if.master   bus,
  output logic [WIDTH-1:0]      seq,
  output logic [DROP_WIDTH-1:0] dropped,
  output logic                  error
);

  localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [PW-1:0] LAST = PW'(FRAME_LEN - 1);

`ifdef FRAME_SUM_EN
  typedef enum logic [1:0] {
    PAYLOAD,
    TRAIL_SEQ,
    TRAIL_SUM
  } state_t;
`else
  typedef enum logic {
    PAYLOAD,
    TRAIL_SEQ
  } state_t;
`endif

  state_t           state;
  logic [PW-1:0]    pos;
  logic             discard;
`ifdef FRAME_SUM_EN
  logic [WIDTH-1:0] sum;
`endif

  logic first;
  logic last;
  logic disc_now;

  assign first    = (pos == '0);
  assign last     = (pos == LAST);
  // almost-full only matters at the first sample of a frame
  assign disc_now = first ? bus.oafull : discard;

  always_ff @(posedge wclock or negedge resetn) begin
    if (!resetn) begin
      state       <= PAYLOAD;
      pos         <= '0;
      discard     <= 1'b0;
`ifdef FRAME_SUM_EN
      sum         <= '0;
`endif
      bus.odata   <= '0;
      bus.oenable <= 1'b0;
      seq         <= '0;
      dropped     <= '0;
      error       <= 1'b0;
    end else begin
      bus.oenable <= 1'b0;
      if (bus.senable && state != PAYLOAD)
        error <= 1'b1;
      case (state)
        PAYLOAD: begin
          if (bus.senable) begin
            discard <= disc_now;
            if (!disc_now) begin
              bus.odata   <= bus.sdata;
              bus.oenable <= 1'b1;
            end
`ifdef FRAME_SUM_EN
            sum <= first ? bus.sdata
                         : sum + bus.sdata;
`endif
            if (last) begin
              pos <= '0;
              if (disc_now) begin
                seq <= seq + 1'b1;
                if (!(&dropped))
                  dropped <= dropped + 1'b1;
              end else begin
                state <= TRAIL_SEQ;
              end
            end else begin
              pos <= pos + 1'b1;
            end
          end
        end
        TRAIL_SEQ: begin
          bus.odata   <= seq;
          bus.oenable <= 1'b1;
`ifdef FRAME_SUM_EN
          state       <= TRAIL_SUM;
`else
          state       <= PAYLOAD;
          seq         <= seq + 1'b1;
`endif
        end
`ifdef FRAME_SUM_EN
        TRAIL_SUM: begin
          bus.odata   <= sum;
          bus.oenable <= 1'b1;
          state       <= PAYLOAD;
          seq         <= seq + 1'b1;
        end
`endif
        default: state <= PAYLOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_push_frame_packer.sv
// tb_push_frame_packer: directed framing, discard, collision,
// wrap/saturation and reset checks with FRAME_LEN=4, WIDTH=8.
module tb_push_frame_packer;

`ifdef FRAME_SUM_EN
  localparam int SP = 3;
  localparam int TL = 2;
`else
  localparam int SP = 2;
  localparam int TL = 1;
`endif

  logic       wclock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] seq;
  logic [7:0] dropped;
  logic       error;

  push_frame_packer_if #(.WIDTH(8)) bus ();

  push_frame_packer #(
    .WIDTH(8),
    .FRAME_LEN(4),
    .DROP_WIDTH(8)
  ) dut (
    .wclock (wclock),
    .resetn (resetn),
    .bus    (bus.master),
    .seq    (seq),
    .dropped(dropped),
    .error  (error)
  );

  always #5 wclock = ~wclock;

  logic [7:0] q[$];
  int npass = 0;
  int ntot  = 0;

  always @(negedge wclock)
    if (resetn && bus.oenable)
      q.push_back(bus.odata);

  task automatic chk(input string tag, input int got, input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  task automatic pop_chk(input string tag, input int exp);
    int g;
    g = -1;
    if (q.size() > 0) g = int'(q.pop_front());
    chk(tag, g, exp);
  endtask

  task automatic frame_chk(input string tag,
                           input int a, input int b,
                           input int c, input int d,
                           input int s, input int sm);
    pop_chk({tag, ".d0"}, a);
    pop_chk({tag, ".d1"}, b);
    pop_chk({tag, ".d2"}, c);
    pop_chk({tag, ".d3"}, d);
    pop_chk({tag, ".seq"}, s);
`ifdef FRAME_SUM_EN
    pop_chk({tag, ".sum"}, sm);
`else
    if (sm < 0) chk({tag, ".sum"}, sm, 0);
`endif
  endtask

  task automatic send(input logic [7:0] d, input int gap,
                      input logic af = 1'b0);
    bus.sdata   = d;
    bus.oafull  = af;
    bus.senable = 1'b1;
    @(negedge wclock);
    bus.senable = 1'b0;
    repeat (gap - 1) @(negedge wclock);
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    bus.oafull = 1'b1;
    repeat (2) @(negedge wclock);
    resetn = 1'b1;
    @(negedge wclock);
    bus.oafull = 1'b0;
    q.delete();
  endtask

  initial begin
    bus.sdata   = '0;
    bus.senable = 1'b0;
    bus.oafull  = 1'b1;
    @(negedge wclock);
    chk("rst.odata",   bus.odata,   0);
    chk("rst.oenable", bus.oenable, 0);
    chk("rst.seq",     seq,         0);
    chk("rst.dropped", dropped,     0);
    chk("rst.error",   error,       0);
    do_reset();

    // basic framing
    send(1, SP); send(2, SP); send(3, SP); send(4, SP);
    send(5, SP); send(6, SP); send(7, SP); send(8, SP);
    repeat (4) @(negedge wclock);
    frame_chk("basic.f0", 1, 2, 3, 4, 8'h00, 8'h0A);
    frame_chk("basic.f1", 5, 6, 7, 8, 8'h01, 8'h1A);
    chk("basic.extra", q.size(), 0);
    chk("basic.error", error, 0);
    chk("basic.seq", seq, 2);
    chk("basic.oen_idle", bus.oenable, 0);
`ifdef FRAME_SUM_EN
    chk("basic.hold", bus.odata, 8'h1A);
`else
    chk("basic.hold", bus.odata, 8'h01);
`endif

    // discard whole frame 1
    do_reset();
    send(10, SP); send(11, SP); send(12, SP); send(13, SP);
    send(20, SP, 1'b1); send(21, SP); send(22, SP); send(23, SP);
    send(30, SP); send(31, SP); send(32, SP); send(33, SP);
    repeat (4) @(negedge wclock);
    frame_chk("disc.f0", 10, 11, 12, 13, 8'h00, 8'h2E);
    frame_chk("disc.f2", 30, 31, 32, 33, 8'h02, 8'h7E);
    chk("disc.extra", q.size(), 0);
    chk("disc.dropped", dropped, 1);

    // almost-full toggling mid-frame is ignored
    send(40, SP, 1'b0); send(41, SP, 1'b1);
    send(42, SP, 1'b0); send(43, SP, 1'b1);
    bus.oafull = 1'b0;
    repeat (4) @(negedge wclock);
    frame_chk("mid.f3", 40, 41, 42, 43, 8'h03, 8'hA6);
    chk("mid.extra", q.size(), 0);
    chk("mid.dropped", dropped, 1);

    // strobe during trailer
    do_reset();
    send(1, SP); send(2, SP); send(3, SP); send(4, 1);
    send(8'h55, SP - 1);
    chk("coll.error", error, 1);
    send(5, SP); send(6, SP); send(7, SP); send(8, SP);
    repeat (4) @(negedge wclock);
    frame_chk("coll.f0", 1, 2, 3, 4, 8'h00, 8'h0A);
    frame_chk("coll.f1", 5, 6, 7, 8, 8'h01, 8'h1A);
    chk("coll.extra", q.size(), 0);
    chk("coll.sticky", error, 1);

    // seq wrap over 257 frames
    do_reset();
    for (int k = 0; k < 257; k++)
      for (int j = 0; j < 4; j++)
        send(8'(k), SP);
    repeat (4) @(negedge wclock);
    chk("wrap.count", q.size(), 257 * (4 + TL));
    for (int k = 0; k < 257; k++) begin
      for (int j = 0; j < 4; j++) void'(q.pop_front());
      pop_chk("wrap.seq", k % 256);
`ifdef FRAME_SUM_EN
      pop_chk("wrap.sum", (4 * k) % 256);
`endif
    end
    chk("wrap.seqreg", seq, 1);

    // dropped saturation over 300 discarded frames
    do_reset();
    for (int k = 0; k < 300; k++)
      for (int j = 0; j < 4; j++)
        send(8'h77, SP, 1'b1);
    bus.oafull = 1'b0;
    repeat (4) @(negedge wclock);
    chk("sat.dropped", dropped, 8'hFF);
    chk("sat.pushes", q.size(), 0);
    chk("sat.seq", seq, 8'h2C);

    // reset mid-frame
    send(9, SP); send(9, SP);
    chk("mrst.pre", bus.odata, 9);
    #2 resetn = 1'b0;
    #1;
    chk("mrst.odata",   bus.odata,   0);
    chk("mrst.oenable", bus.oenable, 0);
    chk("mrst.seq",     seq,         0);
    chk("mrst.dropped", dropped,     0);
    chk("mrst.error",   error,       0);
    do_reset();
    send(1, SP); send(2, SP); send(3, SP); send(4, SP);
    repeat (4) @(negedge wclock);
    frame_chk("mrst.f0", 1, 2, 3, 4, 8'h00, 8'h0A);
    chk("mrst.extra", q.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/push_frame_packer.md
# push_frame_packer

Packs a strobed sample stream into fixed-length frames with a trailer and drives the push (write-enable) side of the team's push-to-AXI-stream FIFO. It sits directly upstream of that FIFO: `odata`/`oenable` connect to the FIFO's `idata`/`ienable`, and the FIFO's `iafull` drives `oafull`. Whole frames are discarded when the FIFO is almost full at frame start. A sequence-number trailer lets the stream consumer detect dropped frames.

## Interface
- `WIDTH`, default 8: sample, output word and sequence-number width.
- `FRAME_LEN`, default 16: payload samples per frame; legal range 2..65535.
- `DROP_WIDTH`, default 8: width of the dropped-frame counter.

Ports (all synchronous to `wclock`):
- `wclock`  in  1  clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `sdata`  in  WIDTH  sample data, valid when `senable`.
- `senable`  in  1  sample strobe; one sample per high cycle.
- `oafull`  in  1  almost-full from the downstream FIFO.
- `odata`  out  WIDTH  pushed word, registered.
- `oenable`  out  1  push strobe, registered.
- `seq`  out  WIDTH  sequence number of the frame currently being collected.
- `dropped`  out  DROP_WIDTH  count of discarded frames; saturating.
- `error`  out  1  sticky flag: a sample arrived during trailer emission.

## Operation
- States: PAYLOAD, TRAIL_SEQ and TRAIL_SUM. TRAIL_SUM exists only with `FRAME_SUM_EN`.
- Internal position counter `pos` runs 0..FRAME_LEN-1. It has `$clog2(FRAME_LEN)` bits.
- PAYLOAD state, when `senable`=1:
  - If `pos`==0, the `discard` flag is latched from `oafull`. `oafull` is ignored at every other position.
  - If `discard`=0, the sample is pushed.
  - The running sum is updated: `sum` is set to `sdata` at `pos`==0, otherwise to `sum+sdata`, both modulo 2^WIDTH.
  - `pos` increments.
- End of payload (sample at `pos`==FRAME_LEN-1):
  - `pos` returns to 0.
  - If not discarded: go to TRAIL_SEQ.
  - If discarded: stay in PAYLOAD; `dropped` increments, saturating at 2^DROP_WIDTH-1.
  - In both cases `seq` increments (wrapping mod 2^WIDTH) once the trailer is complete, or immediately for a discarded frame.
- TRAIL_SEQ: push `seq`. Then go to TRAIL_SUM if compiled in, else PAYLOAD.
- TRAIL_SUM: push `sum`, then go to PAYLOAD.
- `senable`=1 while in a TRAIL state:
  - The sample is dropped and `error` is set, staying set until reset.
  - `pos`, `sum` and the state are unaffected.
- Source contract: consecutive `senable` strobes are at least 3 cycles apart with `FRAME_SUM_EN`, and at least 2 cycles apart without it. The contract matters only across frame ends; within a frame, back-to-back strobes are legal.

## Timing
- Reset values:
  - Outputs: `odata`=0, `oenable`=0, `seq`=0, `dropped`=0, `error`=0.
  - Internal: state PAYLOAD, `pos`=0, `sum`=0, `discard`=0.
- Reset mid-frame abandons the partial frame; no trailer is pushed.
- Latency: a sample strobed at edge t appears on `odata` with `oenable`=1 during cycle t+1.
- Trailer words:
  - The seq word is pushed in the cycle after the last payload push.
  - The sum word, when compiled in, is pushed in the following cycle.
- `oenable` is high for exactly one cycle per pushed word. `odata` holds its last value while `oenable`=0.
- The FIFO drives almost-full high during reset and for the first cycle after it. A frame whose first sample lands in that cycle is therefore discarded by design.

## Configuration
- `FRAME_SUM_EN` defined:
  - Trailer is seq then sum, making each pushed frame FRAME_LEN+2 words.
  - Strobe spacing across a frame end is 3 cycles.
- `FRAME_SUM_EN` undefined:
  - Trailer is seq only, making each pushed frame FRAME_LEN+1 words.
  - TRAIL_SUM state and the `sum` register are absent.
  - Spacing across a frame end is 2 cycles.

## Test plan
Benches use WIDTH=8, FRAME_LEN=4, `FRAME_SUM_EN` defined unless noted.

- Basic framing: `oafull`=0; samples 1,2,3,4 then 5,6,7,8, each 3 cycles apart -> pushes 1,2,3,4,0x00,0x0A then 5,6,7,8,0x01,0x1A; `error`=0.
- Frame discard: frame 0 normal, `oafull`=1 at frame 1's first sample, frame 2 normal -> frame 1 produces no pushes; `dropped`=1; frame 2's seq word is 0x02.
- Mid-frame almost-full: `oafull` toggles during `pos` 1..3 -> whole frame pushed; `dropped` unchanged.
- Collision: strobe 1 cycle after a frame's last sample -> that sample is not pushed; `error`=1 and stays 1; the next frame's payload starts at `pos` 0 with a correct sum.
- Wrap and saturation:
  - 257 pushed frames -> seq words run ...,0xFF,0x00.
  - 300 discarded frames -> `dropped`=0xFF.
- Reset mid-frame: `resetn` low after 2 samples -> all outputs 0. The next frame after reset is 4 samples, and its seq word is 0x00.
- Without `FRAME_SUM_EN`: samples 1..4 every 2 cycles -> pushes 1,2,3,4,0x00; `error`=0.
